// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer control core.
// States, saturation limit and LFSR seed/tap mask.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MEASURE,
    SHOW,
    FALSE
  } state_t;

  localparam logic [15:0] MS_SAT    = 16'd9999;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 in right-shift form land on bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/reaction_timer_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reseeded by reset.
// The seed is non-zero, so the register never reaches the all-zero lock-up state.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= {^(q & LFSR_TAPS), q[15:1]};
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer control: random pre-go delay, ms measurement, result hold.
// Optional best-time tracking is built when BEST_TIME_EN is defined.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int CLKFREQ       = 100,
  parameter int MIN_WAIT_MS   = 1000,
  parameter int CYCLES_PER_MS = CLKFREQ * 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_react,
  output logic        led_go,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        false_start,
  output logic [15:0] best_ms
);

  localparam logic [31:0] TICK_LAST = 32'(CYCLES_PER_MS - 1);

  state_t      state_q, state_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] result_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [15:0] lfsr;
  logic [15:0] arm_delay;
  logic        start_q, start_p;
  logic        react_q, react_p;
  logic        start_edge, react_edge;
  logic        tick;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign start_edge = start_q & ~start_p;
  assign react_edge = react_q & ~react_p;
  assign tick       = (tcnt_q == TICK_LAST);
  assign arm_delay  = 16'(MIN_WAIT_MS) + (lfsr & 16'h07FF);

  always_comb begin
    state_d  = state_q;
    ms_d     = ms_q;
    delay_d  = delay_q;
    result_d = result;
    tcnt_d   = tick ? '0 : tcnt_q + 32'd1;
    unique case (state_q)
      IDLE, SHOW, FALSE: begin
        if (start_edge) begin
          state_d  = WAIT;
          delay_d  = arm_delay;
          ms_d     = '0;
          tcnt_d   = '0;
          result_d = '0;
        end
      end
      WAIT: begin
        if (react_edge) begin
          state_d  = FALSE;
          result_d = '0;
        end else if (ms_q == delay_q) begin
          state_d = MEASURE;
          ms_d    = '0;
          tcnt_d  = '0;
        end else if (tick) begin
          ms_d = ms_q + 16'd1;
        end
      end
      MEASURE: begin
        // a tick in the react cycle completes that millisecond
        if (react_edge) begin
          state_d  = SHOW;
          result_d = tick ? ms_q + 16'd1 : ms_q;
        end else if (tick) begin
          ms_d = ms_q + 16'd1;
          if (ms_q + 16'd1 == MS_SAT) begin
            state_d  = SHOW;
            result_d = MS_SAT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ms_q         <= '0;
      delay_q      <= '0;
      tcnt_q       <= '0;
      start_q      <= 1'b0;
      start_p      <= 1'b0;
      react_q      <= 1'b0;
      react_p      <= 1'b0;
      result       <= '0;
      led_go       <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ms_q         <= ms_d;
      delay_q      <= delay_d;
      tcnt_q       <= tcnt_d;
      start_q      <= btn_start;
      start_p      <= start_q;
      react_q      <= btn_react;
      react_p      <= react_q;
      result       <= result_d;
      led_go       <= (state_d == MEASURE);
      result_valid <= (state_d == SHOW);
      false_start  <= (state_d == FALSE);
    end
  end

`ifdef BEST_TIME_EN
  logic [15:0] best_q;
  logic        best_we;

  // timeouts carry MS_SAT and so can never win the compare
  assign best_we = (state_q == MEASURE) && (state_d == SHOW);

  always_ff @(posedge clk) begin
    if (!reset) begin
      best_q <= MS_SAT;
    end else if (best_we && (result_d < best_q)) begin
      best_q <= result_d;
    end
  end

  assign best_ms = best_q;
`else
  assign best_ms = MS_SAT;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed/randomised bench for reaction_timer_ctrl with a timing model.
// Expected go/show cycles come from the delay and ms arithmetic.
module tb_reaction_timer_ctrl;

  localparam int CPM  = 3;
  localparam int MINW = 2;
  localparam int SAT  = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic        led_go;
  logic [15:0] result;
  logic        result_valid;
  logic        false_start;
  logic [15:0] best_ms;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  int m_best = SAT;
  logic [15:0] m_lfsr = 16'hACE1;

  reaction_timer_ctrl #(
    .CLKFREQ       (1),
    .MIN_WAIT_MS   (MINW),
    .CYCLES_PER_MS (CPM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_start    (btn_start),
    .btn_react    (btn_react),
    .led_go       (led_go),
    .result       (result),
    .result_valid (result_valid),
    .false_start  (false_start),
    .best_ms      (best_ms)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] b;
    b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'd1;
    return (x >> 1) | (b << 15);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int exp_best();
`ifdef BEST_TIME_EN
    return m_best;
`else
    return SAT;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit with_react, output int s,
                             output int d);
    int r;
    btn_start = 1'b1;
    btn_react = with_react;
    r = cyc;
    @(negedge clk);
    d = MINW + int'(m_lfsr & 16'h07FF);
    btn_start = 1'b0;
    btn_react = 1'b0;
    @(negedge clk);
    s = r + 2;
  endtask

  task automatic wait_go(input int s, input int d, output int e);
    int n;
    int bound;
    n = 0;
    bound = d * CPM + 20;
    while (led_go !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    e = cyc;
    chk("go_cycle", 32'(cyc), 32'(s + d * CPM + 1));
  endtask

  task automatic react_at(input int e, input int n, input bit with_start,
                          output int res);
    int r;
    int k;
    while (cyc < e + n) @(negedge clk);
    btn_react = 1'b1;
    btn_start = with_start;
    r = cyc;
    @(negedge clk);
    btn_react = 1'b0;
    btn_start = 1'b0;
    k = 0;
    while (result_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    res = (r + 2 - e) / CPM;
    chk("show_cycle", 32'(cyc), 32'(r + 2));
    chk("result", 32'(result), 32'(res));
    chk("led_off", 32'(led_go), 32'd0);
    if (res < m_best) m_best = res;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int s, d, e, res, r, k;
    int runs[3];
    runs[0] = 120;
    runs[1] = 85;
    runs[2] = 200;

    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led_go), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_false", 32'(false_start), 32'd0);
    chk("rst_best", 32'(best_ms), 32'(SAT));
    reset = 1'b1;

    // react presses in IDLE must be ignored
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i % 7 == 0) btn_react = 1'($urandom_range(0, 1));
      if (i % 1000 == 999) begin
        chk("idle_led", 32'(led_go), 32'd0);
        chk("idle_valid", 32'(result_valid), 32'd0);
        chk("idle_result", 32'(result), 32'd0);
      end
    end
    btn_react = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_best", 32'(best_ms), 32'(SAT));

    pulse_start(1'b0, s, d);
    chk("arm_false", 32'(false_start), 32'd0);
    wait_go(s, d, e);
    react_at(e, 37 * CPM, 1'b0, res);
    chk("run37", 32'(result), 32'd37);
    chk("best37", 32'(best_ms), 32'(exp_best()));
    for (int i = 0; i < 10; i++) begin
      repeat (1000) @(negedge clk);
      chk("hold_result", 32'(result), 32'd37);
      chk("hold_valid", 32'(result_valid), 32'd1);
    end

    pulse_start(1'b0, s, d);
    chk("rearm_result", 32'(result), 32'd0);
    chk("rearm_valid", 32'(result_valid), 32'd0);
    wait_go(s, d, e);
    react_at(e, $urandom_range(1, 400), 1'b0, res);
    chk("best_rand", 32'(best_ms), 32'(exp_best()));

    pulse_start(1'b0, s, d);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    btn_react = 1'b1;
    r = cyc;
    @(negedge clk);
    btn_react = 1'b0;
    @(negedge clk);
    chk("fs_cycle", 32'(cyc), 32'(r + 2));
    chk("fs_flag", 32'(false_start), 32'd1);
    chk("fs_result", 32'(result), 32'd0);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (led_go !== 1'b0) k++;
    end
    chk("fs_no_go", 32'(k), 32'd0);
    chk("fs_best", 32'(best_ms), 32'(exp_best()));

    pulse_start(1'b0, s, d);
    chk("fs_clear", 32'(false_start), 32'd0);
    wait_go(s, d, e);
    k = 0;
    while (result_valid !== 1'b1 && k < SAT * CPM + 20) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycle", 32'(cyc), 32'(e + SAT * CPM));
    chk("tmo_result", 32'(result), 32'(SAT));
    chk("tmo_best", 32'(best_ms), 32'(exp_best()));

    pulse_start(1'b0, s, d);
    btn_start = 1'b1;
    btn_react = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    btn_react = 1'b0;
    @(negedge clk);
    chk("both_wait_fs", 32'(false_start), 32'd1);
    chk("both_wait_res", 32'(result), 32'd0);
    chk("both_wait_led", 32'(led_go), 32'd0);

    // start wins over react when both arrive in FALSE
    pulse_start(1'b1, s, d);
    chk("both_false_fs", 32'(false_start), 32'd0);
    wait_go(s, d, e);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_led", 32'(led_go), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_valid", 32'(result_valid), 32'd0);
    chk("mrst_best", 32'(best_ms), 32'(SAT));
    reset = 1'b1;
    m_best = SAT;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      pulse_start(1'b0, s, d);
      wait_go(s, d, e);
      react_at(e, runs[i] * CPM, i == 1, res);
      chk("run_result", 32'(result), 32'(runs[i]));
      repeat (5) @(negedge clk);
      chk("run_hold", 32'(result_valid), 32'd1);
      chk("run_best", 32'(best_ms), 32'(exp_best()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
# reaction_timer_ctrl

Control core of the reaction timer, upstream of the seven-segment display driver. Handles the start button, waits a pseudo-random delay, lights the "go" LED, and counts milliseconds until the react button is pressed. Its 16-bit binary millisecond result feeds the display driver's `indata`, which performs the BCD conversion and multiplexing.

## Interface
- `CLKFREQ`, 100, clock frequency in MHz; `CYCLES_PER_MS = CLKFREQ*1000`
- `MIN_WAIT_MS`, 1000, fixed part of the random pre-go delay in ms
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `btn_start`  in  1  debounced start button, level, active-high
- `btn_react`  in  1  debounced react button, level, active-high
- `led_go`  out  1  go LED, high only in MEASURE
- `result`  out  16  reaction time in ms, binary, range 0..9999
- `result_valid`  out  1  high while a finished result is held (SHOW)
- `false_start`  out  1  high while in FALSE state
- `best_ms`  out  16  best (minimum) valid result; see Configuration

## Operation
- Buttons are registered once. `*_edge = cur & ~prev`. Only edges act; held levels are ignored.
- The 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) is free-running and advances every clock. It never holds zero; reset reloads the seed.
- A ms-tick counter counts 0..CYCLES_PER_MS-1. It pulses `tick` on wrap and is cleared on entry to WAIT and to MEASURE.
- States and transitions:
  - IDLE: on start_edge go to WAIT. Capture `delay_ms = MIN_WAIT_MS + lfsr[10:0]`, clear the ms counter, and clear `result` to 0.
  - WAIT: on a tick, increment the ms counter. On react_edge go to FALSE (takes priority over delay expiry). When `ms == delay_ms`, go to MEASURE and clear `ms` and the tick counter.
  - MEASURE: on a tick, increment `ms`, saturating at 9999. On react_edge go to SHOW with `result <= ms`, or `ms+1` if a tick occurs in the same cycle. When `ms` reaches 9999, go to SHOW with `result = 9999` (timeout).
  - SHOW / FALSE: hold outputs. On start_edge behave as in IDLE (immediate re-arm into WAIT).
- Simultaneous start_edge and react_edge:
  - in IDLE/SHOW/FALSE, start wins;
  - in WAIT, react wins (false start);
  - in MEASURE, react is honoured and start is ignored.
- FALSE sets `result = 0`.
- Width rule: the ms counter and `result` are 16 bits. 9999 < 2^14, so there is no overflow.

## Timing
- Reset values:
  - state = IDLE
  - `led_go` = 0
  - `result` = 0
  - `result_valid` = 0
  - `false_start` = 0
  - `best_ms` = 9999
  - lfsr = 16'hACE1
  - counters = 0
- All outputs are registered.
- Button latency: a button rise at cycle n produces an edge at n+1 and the state change at n+2.
- Measurement:
  - `led_go` rises in the cycle MEASURE is entered.
  - `result` equals the number of full ms between `led_go` rising and the registered react edge.
  - Accuracy is ±1 ms minus 2 cycles of synchroniser latency.
- `result_valid` and `result` update in the same cycle. `result` is stable for the whole of SHOW.
- A reset asserted mid-operation returns to IDLE on the next edge, even during MEASURE; no partial result is kept.

## Configuration
- `BEST_TIME_EN` defined:
  - On each MEASURE→SHOW transition, if `result < best_ms`, then `best_ms <= result`.
  - Timeouts (9999) never lower it.
  - FALSE never updates it.
  - Only reset restores 9999.
- Not defined: `best_ms` is tied to constant 16'd9999 and no comparator or register is built.

## Structure
- Package `reaction_pkg`:
  - state enum (IDLE, WAIT, MEASURE, SHOW, FALSE)
  - `MS_SAT = 16'd9999`
  - `LFSR_SEED = 16'hACE1`
  - LFSR tap mask
- Sub-module `lfsr16` (`clk`, `reset`, `q[15:0]`): free-running, seeded on reset. Everything else stays in `reaction_timer_ctrl`.
- Target size is about 150–250 lines.

## Test plan
Bench parameters: `CLKFREQ=1`, so one ms is 1000 cycles; `MIN_WAIT_MS=2`.

- Reset then idle 5000 cycles -> `led_go=0`, `result=0`, `result_valid=0`, `best_ms=9999`.
- start pulse; react exactly 37 ms (37000 cycles) after `led_go` rises -> `result=37`, `result_valid=1`. `result` holds through 10000 further cycles.
- start pulse; react pulse during WAIT -> `false_start=1`, `result=0`, `led_go` never rises. The next start clears `false_start` and re-arms.
- start pulse, no react -> `result=9999` exactly 9999 ms after `led_go` rises; `best_ms` unchanged.
- With `BEST_TIME_EN`, runs of 120, 85, then 200 ms -> `best_ms` goes 120, 85, 85. Without the macro it stays 9999 throughout.
- Reset asserted mid-MEASURE -> the next cycle is IDLE with `led_go=0` and `result=0`. Same-cycle start and react in WAIT -> FALSE.
